// File: rtl/bk_uart_pkg.sv
// Shared types and defaults for the bk UART transmit-side arbitration blocks.
// Holds the arbiter state encoding, default sizing and a width helper.
package bk_uart_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_BUSY_TIMEOUT = 16;
    localparam int DEF_CNT_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } tx_state_e;

    // Minimum bit width able to index n items; never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bk_rr_pick.sv
// Combinational round-robin picker: the first valid index above the last
// grant, wrapping modulo N. Reusable by any bk arbiter.
module bk_rr_pick
    import bk_uart_pkg::*;
#(
    parameter  int N  = DEF_NUM_REQ,
    localparam int GW = clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [GW-1:0] last,
    output logic [GW-1:0] winner,
    output logic          any_valid
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        logic [GW-1:0] idx;
        winner    = last;
        any_valid = 1'b0;
        idx       = '0;
        // Walk from the lowest priority down so the nearest valid index wins.
        for (int s = N; s >= 1; s--) begin
            idx = GW'((int'(last) + s) % N);
            if (valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bk_uart_tx_arb.sv
// Round-robin share of one UART TX engine between NUM_REQ byte requesters,
// sequencing the start/busy handshake with a busy-rise timeout.
module bk_uart_tx_arb
    import bk_uart_pkg::*;
#(
    parameter  int NUM_REQ      = DEF_NUM_REQ,
    parameter  int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    parameter  int CNT_W        = DEF_CNT_W,
    localparam int GW           = clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_start_o,
    input  logic                 tx_busy_i,
    output logic [GW-1:0]        grant_id_o,
    output logic                 active_o,
    output logic                 err_timeout_o,
    input  logic                 err_clr_i,
    output logic [CNT_W-1:0]     sent_cnt_o
);

    localparam int            TW       = clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    tx_state_e     state;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] pick_idx;
    logic          pick_any;

    bk_rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .valid     (req_valid_i),
        .last      (grant_id_o),
        .winner    (pick_idx),
        .any_valid (pick_any)
    );

    assign active_o = (state != ST_IDLE);

    // NOTE: all state updates use non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            tmo_cnt       <= '0;
            tx_data_o     <= '0;
            tx_start_o    <= 1'b0;
            req_ready_o   <= '0;
            grant_id_o    <= GW'(NUM_REQ - 1);
            err_timeout_o <= 1'b0;
            sent_cnt_o    <= '0;
        end else begin
            tx_start_o  <= 1'b0;
            req_ready_o <= '0;
            // Clear comes first so a timeout set later in this block wins.
            if (err_clr_i) begin
                err_timeout_o <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!tx_busy_i && pick_any) begin
                        tx_data_o   <= req_data_i[{pick_idx, 3'b000} +: 8];
                        grant_id_o  <= pick_idx;
                        tx_start_o  <= 1'b1;
                        req_ready_o <= NUM_REQ'(1) << pick_idx;
                        state       <= ST_START;
                    end
                end

                ST_START: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT_BUSY;
                end

                ST_WAIT_BUSY: begin
                    if (tx_busy_i) begin
                        state <= ST_WAIT_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt       <= tmo_cnt + TW'(1);
                        err_timeout_o <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                ST_WAIT_DONE: begin
                    // Frame length depends on baud rate, so no timeout here.
                    if (!tx_busy_i) begin
                        sent_cnt_o <= sent_cnt_o + CNT_W'(1);
                        state      <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bk_uart_tx_arb.sv
// Scoreboard bench for bk_uart_tx_arb: requester queues, an engine model and a
// round-robin reference predicting the grant/byte order of every start pulse.
module tb_bk_uart_tx_arb;

    localparam int NUM_REQ      = 4;
    localparam int BUSY_TIMEOUT = 16;
    localparam int CNT_W        = 16;
    localparam int GW           = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ*8-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [7:0]           tx_data_o;
    logic                 tx_start_o;
    logic                 tx_busy_i;
    logic [GW-1:0]        grant_id_o;
    logic                 active_o;
    logic                 err_timeout_o;
    logic                 err_clr_i;
    logic [CNT_W-1:0]     sent_cnt_o;

    logic eng_busy;
    logic ext_busy;
    assign tx_busy_i = eng_busy | ext_busy;

    bk_uart_tx_arb #(
        .NUM_REQ      (NUM_REQ),
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_data_i    (req_data_i),
        .req_ready_o   (req_ready_o),
        .tx_data_o     (tx_data_o),
        .tx_start_o    (tx_start_o),
        .tx_busy_i     (tx_busy_i),
        .grant_id_o    (grant_id_o),
        .active_o      (active_o),
        .err_timeout_o (err_timeout_o),
        .err_clr_i     (err_clr_i),
        .sent_cnt_o    (sent_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rq[NUM_REQ][$];
    int         ref_last;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         n_starts = 0;
    int         last_start = 0;
    int         exp_sent = 0;
    int         eng_dly  = 2;
    int         eng_len  = 10;
    bit         eng_on   = 1'b1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: round robin over the requester queues, one byte per grant.
    task automatic predict(output int total);
        int   cnt[NUM_REQ];
        int   k;
        exp_t e;
        total = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt[i] = rq[i].size();
            total += cnt[i];
        end
        for (int n = 0; n < total; n++) begin
            for (int s = 1; s <= NUM_REQ; s++) begin
                k = (ref_last + s) % NUM_REQ;
                if (cnt[k] > 0) begin
                    e.id   = k;
                    e.data = rq[k][rq[k].size() - cnt[k]];
                    exp_q.push_back(e);
                    cnt[k]--;
                    ref_last = k;
                    break;
                end
            end
        end
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget &&
               !(queues_empty() && !active_o && !tx_busy_i && exp_q.size() == 0)) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            $display("FAIL %s: idle not reached within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_start(input string name, input int budget);
        int n;
        n = 0;
        while (!tx_start_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            $display("FAIL %s: no start pulse within %0d cycles", name, budget);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_active"},  active_o,      0);
        check({tag, "_start"},   tx_start_o,    0);
        check({tag, "_ready"},   req_ready_o,   0);
        check({tag, "_err"},     err_timeout_o, 0);
        check({tag, "_sent"},    sent_cnt_o,    0);
        check({tag, "_tx_data"}, tx_data_o,     0);
        check({tag, "_grant"},   grant_id_o,    NUM_REQ - 1);
    endtask

    // Requesters: present the head of each queue, pop it on its ready pulse.
    initial begin
        req_valid_i = '0;
        req_data_i  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_ready_o[k] && rq[k].size() > 0) void'(rq[k].pop_front());
                req_valid_i[k]       = (rq[k].size() > 0);
                req_data_i[k*8 +: 8] = (rq[k].size() > 0) ? rq[k][0] : 8'h00;
            end
        end
    end

    // Engine model: busy rises eng_dly cycles after a start, holds eng_len cycles.
    initial begin
        eng_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start_o && eng_on) begin
                repeat (eng_dly) @(posedge clk);
                #1 eng_busy = 1'b1;
                repeat (eng_len) @(posedge clk);
                #1 eng_busy = 1'b0;
            end
        end
    end

    // Monitor: every start/ready pulse is matched against the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (tx_start_o || req_ready_o != '0)) begin
                n_starts++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_start: grant %0d data 0x%02h, nothing expected",
                             grant_id_o, tx_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("start_pulse", tx_start_o, 1);
                    check("grant_id",    grant_id_o, e.id);
                    check("tx_data",     tx_data_o,  e.data);
                    check("req_ready",   req_ready_o, 1 << e.id);
                    if (n_starts > 1) check("start_gap_ge4", (cyc - last_start) >= 4, 1);
                end
                last_start = cyc;
            end
        end
    end

    initial begin
        int tot;
        int n;
        int s0;
        rst       = 1'b1;
        ext_busy  = 1'b0;
        err_clr_i = 1'b0;
        ref_last  = NUM_REQ - 1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Single request on requester 0.
        @(negedge clk);
        eng_dly = 2;
        eng_len = 10;
        rq[0].push_back(8'h5A);
        predict(tot);
        exp_sent += tot;
        wait_idle("single", 300);
        check("single_sent", sent_cnt_o, exp_sent);
        check("tx_data_hold_idle", tx_data_o, 8'h5A);

        // Reset between phases so the rotation restarts at requester 0.
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("reset2");
        rst      = 1'b0;
        ref_last = NUM_REQ - 1;
        exp_sent = 0;

        // All four requesters held valid for two rounds.
        eng_dly = 2;
        eng_len = 3;
        for (int k = 0; k < NUM_REQ; k++) begin
            rq[k].push_back(8'h10 + 8'(k));
            rq[k].push_back(8'h10 + 8'(k));
        end
        predict(tot);
        exp_sent += tot;
        wait_idle("all_valid", 1000);
        check("all_valid_sent", sent_cnt_o, 8);

        // Randomized rounds.
        for (int r = 0; r < 4; r++) begin
            eng_dly = $urandom_range(1, 4);
            eng_len = $urandom_range(1, 12);
            for (int k = 0; k < NUM_REQ; k++) begin
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) rq[k].push_back(8'($urandom));
            end
            predict(tot);
            exp_sent += tot;
            wait_idle("random", 3000);
            check("random_sent", sent_cnt_o, exp_sent);
        end

        // Engine never responds: timeout path.
        eng_on = 1'b0;
        rq[2].push_back(8'hC3);
        predict(tot);
        wait_start("timeout_start", 50);
        n = 0;
        while (!err_timeout_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles",  n, BUSY_TIMEOUT + 1);
        check("timeout_idle",    active_o, 0);
        check("timeout_sent",    sent_cnt_o, exp_sent);
        repeat (3) @(negedge clk);
        check("timeout_sticky",  err_timeout_o, 1);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        check("timeout_cleared", err_timeout_o, 0);
        wait_idle("timeout", 100);
        eng_on = 1'b1;

        // Engine busy held externally blocks any grant.
        eng_dly  = 2;
        eng_len  = 4;
        ext_busy = 1'b1;
        rq[1].push_back(8'h7E);
        predict(tot);
        exp_sent += tot;
        s0 = n_starts;
        repeat (8) @(negedge clk);
        check("busy_block_starts", n_starts, s0);
        check("busy_block_active", active_o, 0);
        ext_busy = 1'b0;
        @(negedge clk);
        check("busy_release_start", tx_start_o, 1);
        check("busy_release_grant", grant_id_o, 1);
        wait_idle("ext_busy", 300);
        check("ext_busy_sent", sent_cnt_o, exp_sent);

        // Reset during WAIT_DONE, then requester 0 is served ahead of 1.
        eng_dly = 2;
        eng_len = 20;
        rq[0].push_back(8'hA1);
        predict(tot);
        wait_start("rst_start", 50);
        repeat (5) @(negedge clk);
        check("in_wait_done_active", active_o, 1);
        check("in_wait_done_busy",   tx_busy_i, 1);
        rq[0].push_back(8'hB0);
        rq[1].push_back(8'hB1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        rst      = 1'b0;
        ref_last = NUM_REQ - 1;
        exp_sent = 0;
        predict(tot);
        exp_sent += tot;
        wait_idle("after_reset", 500);
        check("after_reset_sent", sent_cnt_o, exp_sent);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
